// File: rtl/wasm_rom_parser_if.sv
// Byte-wide shared memory port between the ROM parser (master) and memory (slave).
interface wasm_rom_parser_if;
  logic        mem_access;
  logic [31:0] addr;
  logic        memory_read_en;
  logic        memory_write_en;
  logic [7:0]  data_out;
  logic        memory_ready;

  modport master (
    input  mem_access,
    input  data_out,
    input  memory_ready,
    output addr,
    output memory_read_en,
    output memory_write_en
  );

  modport slave (
    output mem_access,
    output data_out,
    output memory_ready,
    input  addr,
    input  memory_read_en,
    input  memory_write_en
  );
endinterface

// File: rtl/wasm_rom_parser.sv
// Bootstrap parser: walks a WebAssembly image in ROM byte by byte and publishes
// the address of the first opcode of function body 0 for the CPU.
module wasm_rom_parser #(
  parameter logic [31:0] ROM_BASE = 32'd0,
  parameter logic [31:0] ROM_SIZE = 32'd4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  wasm_rom_parser_if.master     bus,
  output logic                  rom_mapped,
  output logic [31:0]           first_instruction,
  output logic [31:0]           func_count,
  output logic                  parse_error,
  output logic [2:0]            error_code,
  output logic                  busy
);

  localparam logic [31:0] ROM_LIMIT   = ROM_BASE + ROM_SIZE;
  localparam logic [63:0] MAGIC_WORD  = 64'h0061_736D_0100_0000;

  localparam logic [2:0] ERR_MAGIC    = 3'd1;
  localparam logic [2:0] ERR_BOUNDS   = 3'd2;
  localparam logic [2:0] ERR_LEB      = 3'd3;
  localparam logic [2:0] ERR_NO_FUNCS = 3'd4;
  localparam logic [2:0] ERR_SEC_ID   = 3'd5;

  typedef enum logic [3:0] {
    IDLE,
    MAGIC,
    SEC_ID,
    SEC_SIZE,
    CODE_COUNT,
    BODY_SIZE,
    LOCALS_COUNT,
    LOCAL_N,
    LOCAL_TYPE,
    DONE,
    ERROR
  } state_t;

  state_t      state;
  logic [31:0] cursor;
  logic [31:0] addr_q;
  logic        read_en_q;
  logic        need_low;
  logic [2:0]  magic_idx;
  logic [3:0]  sec_id;
  logic [31:0] leb_acc;
  logic [2:0]  leb_n;
  logic [31:0] locals_left;

  logic        ready_eff;
  logic        captured;
  logic        rd_state;
  logic        issue;
  logic        in_bounds;
  logic [7:0]  rd_byte;
  logic [7:0]  magic_byte;
  logic [5:0]  leb_shift;
  logic [31:0] leb_val;
  logic        leb_last;
  logic        leb_overflow;
  logic        fail;
  logic [2:0]  fail_code;

  // The bus is released entirely while another master owns the port.
  assign bus.addr            = bus.mem_access ? addr_q    : 'z;
  assign bus.memory_read_en  = bus.mem_access ? read_en_q : 1'bz;
  assign bus.memory_write_en = bus.mem_access ? 1'b0      : 1'bz;

  assign ready_eff    = bus.mem_access & bus.memory_ready;
  assign captured     = read_en_q & ready_eff;
  assign rd_state     = !(state inside {IDLE, DONE, ERROR});
  assign issue        = rd_state && !read_en_q && (!need_low || !ready_eff);
  assign in_bounds    = cursor < ROM_LIMIT;
  assign rd_byte      = bus.data_out;
  assign magic_byte   = MAGIC_WORD[{3'd7 - magic_idx, 3'b000} +: 8];
  assign leb_shift    = 6'(leb_n) * 6'd7;
  assign leb_val      = leb_acc | ({25'd0, rd_byte[6:0]} << leb_shift);
  assign leb_last     = !rd_byte[7];
  assign leb_overflow = rd_byte[7] && (leb_n == 3'd4);

  // Failure detection for the byte being requested or the byte just captured.
  always_comb begin
    fail      = 1'b0;
    fail_code = 3'd0;
    if (issue && !in_bounds) begin
      fail      = 1'b1;
      fail_code = ERR_BOUNDS;
    end else if (captured) begin
      case (state)
        MAGIC: begin
          if (rd_byte != magic_byte) begin
            fail      = 1'b1;
            fail_code = ERR_MAGIC;
          end
        end
        SEC_ID: begin
          if (rd_byte > 8'd12) begin
            fail      = 1'b1;
            fail_code = ERR_SEC_ID;
          end
        end
        SEC_SIZE, BODY_SIZE, LOCALS_COUNT, LOCAL_N: begin
          if (leb_overflow) begin
            fail      = 1'b1;
            fail_code = ERR_LEB;
          end
        end
        CODE_COUNT: begin
          if (leb_overflow) begin
            fail      = 1'b1;
            fail_code = ERR_LEB;
          end else if (leb_last && (leb_val == 32'd0)) begin
            fail      = 1'b1;
            fail_code = ERR_NO_FUNCS;
          end
        end
        default: ;
      endcase
    end
  end

  // Main parser FSM; every byte goes through request -> capture -> wait-for-ready-low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      cursor            <= ROM_BASE;
      addr_q            <= 32'd0;
      read_en_q         <= 1'b0;
      need_low          <= 1'b0;
      magic_idx         <= 3'd0;
      sec_id            <= 4'd0;
      leb_acc           <= 32'd0;
      leb_n             <= 3'd0;
      locals_left       <= 32'd0;
      rom_mapped        <= 1'b0;
      first_instruction <= 32'd0;
      func_count        <= 32'd0;
      parse_error       <= 1'b0;
      error_code        <= 3'd0;
      busy              <= 1'b0;
    end else begin
      if (!ready_eff) need_low <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= MAGIC;
            busy      <= 1'b1;
            cursor    <= ROM_BASE;
            magic_idx <= 3'd0;
            leb_acc   <= 32'd0;
            leb_n     <= 3'd0;
          end
        end
        DONE, ERROR: begin
          read_en_q <= 1'b0;
        end
        default: begin
          if (fail) begin
            state       <= ERROR;
            parse_error <= 1'b1;
            error_code  <= fail_code;
            busy        <= 1'b0;
            read_en_q   <= 1'b0;
          end else if (issue) begin
            addr_q    <= cursor;
            read_en_q <= 1'b1;
          end else if (captured) begin
            read_en_q <= 1'b0;
            need_low  <= 1'b1;
            cursor    <= cursor + 32'd1;
            case (state)
              MAGIC: begin
                if (magic_idx == 3'd7) state <= SEC_ID;
                else magic_idx <= magic_idx + 3'd1;
              end
              SEC_ID: begin
                sec_id <= rd_byte[3:0];
                state  <= SEC_SIZE;
              end
              LOCAL_TYPE: begin
                locals_left <= locals_left - 32'd1;
                if (locals_left == 32'd1) begin
                  state             <= DONE;
                  rom_mapped        <= 1'b1;
                  first_instruction <= cursor + 32'd1;
                  busy              <= 1'b0;
                end else begin
                  state <= LOCAL_N;
                end
              end
              default: begin
                if (!leb_last) begin
                  leb_acc <= leb_val;
                  leb_n   <= leb_n + 3'd1;
                end else begin
                  leb_acc <= 32'd0;
                  leb_n   <= 3'd0;
                  case (state)
                    SEC_SIZE: begin
                      if (sec_id == 4'd10) begin
                        state <= CODE_COUNT;
                      end else begin
                        // Skip the payload without reading it; bounds are checked on the next request.
                        cursor <= cursor + 32'd1 + leb_val;
                        state  <= SEC_ID;
                      end
                    end
                    CODE_COUNT: begin
                      func_count <= leb_val;
                      state      <= BODY_SIZE;
                    end
                    BODY_SIZE: begin
                      state <= LOCALS_COUNT;
                    end
                    LOCALS_COUNT: begin
                      if (leb_val == 32'd0) begin
                        state             <= DONE;
                        rom_mapped        <= 1'b1;
                        first_instruction <= cursor + 32'd1;
                        busy              <= 1'b0;
                      end else begin
                        locals_left <= leb_val;
                        state       <= LOCAL_N;
                      end
                    end
                    LOCAL_N: begin
                      state <= LOCAL_TYPE;
                    end
                    default: ;
                  endcase
                end
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wasm_rom_parser.sv
// Directed table-driven bench for wasm_rom_parser with a small ROM model (ROM_SIZE = 64).
module tb_wasm_rom_parser;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        rom_mapped;
  logic [31:0] first_instruction;
  logic [31:0] func_count;
  logic        parse_error;
  logic [2:0]  error_code;
  logic        busy;

  int checks = 0;
  int errors = 0;

  wasm_rom_parser_if bus ();

  wasm_rom_parser #(
    .ROM_BASE(32'd0),
    .ROM_SIZE(32'd64)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .bus               (bus),
    .rom_mapped        (rom_mapped),
    .first_instruction (first_instruction),
    .func_count        (func_count),
    .parse_error       (parse_error),
    .error_code        (error_code),
    .busy              (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model with a programmable number of wait cycles before each ready pulse.
  logic [7:0] mem [0:255];
  int         reads [0:255];
  int         mem_delay;
  int         wait_cnt;

  always @(posedge clk) begin
    if (bus.mem_access && bus.memory_read_en === 1'b1 && bus.memory_ready)
      reads[bus.addr[7:0]] <= reads[bus.addr[7:0]] + 1;
    if (bus.memory_ready) begin
      bus.memory_ready <= 1'b0;
    end else if (bus.mem_access && bus.memory_read_en === 1'b1) begin
      if (wait_cnt >= mem_delay) begin
        bus.memory_ready <= 1'b1;
        bus.data_out     <= mem[bus.addr[7:0]];
        wait_cnt         <= 0;
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end else begin
      wait_cnt <= 0;
    end
  end

  typedef struct packed {
    logic [191:0] img;
    int           len;
    int           delay;
    bit           exp_mapped;
    logic [31:0]  exp_fi;
    logic [31:0]  exp_fc;
    bit           exp_err;
    logic [2:0]   exp_code;
    int           last_read;
    int           never_lo;
    int           never_hi;
  } vec_t;

  localparam int NVEC = 12;
  vec_t vecs [NVEC];

  function automatic vec_t mk(logic [191:0] img, int len, int delay, bit mapped,
                              logic [31:0] fi, logic [31:0] fc, bit err, logic [2:0] code,
                              int last_read, int never_lo, int never_hi);
    vec_t v;
    v.img = img; v.len = len; v.delay = delay; v.exp_mapped = mapped;
    v.exp_fi = fi; v.exp_fc = fc; v.exp_err = err; v.exp_code = code;
    v.last_read = last_read; v.never_lo = never_lo; v.never_hi = never_hi;
    return v;
  endfunction

  task automatic checkVal(string what, int idx, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s (vec %0d): got 0x%0h, expected 0x%0h", what, idx, act, exp);
    end
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic loadRom(vec_t v);
    for (int i = 0; i < 256; i++) begin
      mem[i]   = 8'h00;
      reads[i] = 0;
    end
    for (int i = 0; i < v.len; i++) mem[i] = v.img[(v.len - 1 - i) * 8 +: 8];
    mem_delay = v.delay;
  endtask

  task automatic startAndWait(int idx);
    bit finished;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkVal("busy_after_start", idx, {31'd0, busy}, 32'd1);
    finished = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!busy) begin
        finished = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!finished) begin
      errors++;
      $display("[TB] FAIL timeout (vec %0d): busy still 1, expected 0 within 3000 cycles", idx);
    end
  endtask

  task automatic checkOutput(vec_t v, int idx);
    int bad_addr;
    int bad_cnt;
    int exp_cnt;
    checkVal("rom_mapped", idx, {31'd0, rom_mapped}, {31'd0, v.exp_mapped});
    checkVal("first_instruction", idx, first_instruction, v.exp_fi);
    checkVal("func_count", idx, func_count, v.exp_fc);
    checkVal("parse_error", idx, {31'd0, parse_error}, {31'd0, v.exp_err});
    checkVal("error_code", idx, {29'd0, error_code}, {29'd0, v.exp_code});
    checkVal("busy_end", idx, {31'd0, busy}, 32'd0);
    bad_addr = -1;
    bad_cnt  = 0;
    exp_cnt  = 0;
    for (int i = 0; i < 256; i++) begin
      exp_cnt = (i <= v.last_read && !(i >= v.never_lo && i <= v.never_hi)) ? 1 : 0;
      if (reads[i] != exp_cnt && bad_addr < 0) begin
        bad_addr = i;
        bad_cnt  = exp_cnt;
      end
    end
    checks++;
    if (bad_addr >= 0) begin
      errors++;
      $display("[TB] FAIL read_map (vec %0d): address %0d read %0d times, expected %0d",
               idx, bad_addr, reads[bad_addr], bad_cnt);
    end
  endtask

  task automatic applyStimulus(vec_t v, int idx);
    resetDut();
    loadRom(v);
    startAndWait(idx);
    repeat (3) @(negedge clk);
    checkOutput(v, idx);
  endtask

  initial begin
    bit seen;
    rst_n            = 1'b0;
    start            = 1'b0;
    bus.mem_access   = 1'b1;
    bus.memory_ready = 1'b0;
    bus.data_out     = 8'h00;
    mem_delay        = 0;
    wait_cnt         = 0;
    for (int i = 0; i < 256; i++) begin
      mem[i]   = 8'h00;
      reads[i] = 0;
    end

    //             image                                                       len dly map fi     fc      err code last nlo nhi
    vecs[0]  = mk(192'h0061736D01000000_0A06010400412A0B,                      16, 0, 1, 32'h0D, 32'd1,   0, 3'd0, 12,  1, 0);
    vecs[1]  = mk(192'h0061736D01000000_010401600000_0A06010400412A0B,         22, 0, 1, 32'h13, 32'd1,   0, 3'd0, 18, 10, 13);
    vecs[2]  = mk(192'h0061736D01000000_0A09010701027F41011A0B,                19, 0, 1, 32'h0F, 32'd1,   0, 3'd0, 14,  1, 0);
    vecs[3]  = mk(192'h0061736D01000000_0A09010701027F41011A0B,                19, 3, 1, 32'h0F, 32'd1,   0, 3'd0, 14,  1, 0);
    vecs[4]  = mk(192'h0062736D01000000,                                        8, 0, 0, 32'h00, 32'd0,   1, 3'd1,  1,  1, 0);
    vecs[5]  = mk(192'h0061736D01000000_008001,                                11, 0, 0, 32'h00, 32'd0,   1, 3'd2, 10,  1, 0);
    vecs[6]  = mk(192'h0061736D01000000_008080808080,                          14, 0, 0, 32'h00, 32'd0,   1, 3'd3, 13,  1, 0);
    vecs[7]  = mk(192'h0061736D01000000_0D,                                     9, 0, 0, 32'h00, 32'd0,   1, 3'd5,  8,  1, 0);
    vecs[8]  = mk(192'h0061736D01000000_0A0100,                                11, 0, 0, 32'h00, 32'd0,   1, 3'd4, 10,  1, 0);
    vecs[9]  = mk(192'h0061736D01000000_0036,                                  10, 0, 0, 32'h00, 32'd0,   1, 3'd2,  9,  1, 0);
    vecs[10] = mk(192'h0061736D01000000_0000_0A06010400412A0B,                 18, 1, 1, 32'h0F, 32'd1,   0, 3'd0, 14,  1, 0);
    vecs[11] = mk(192'h0061736D01000000_0A0781010400412A0B,                   17, 0, 1, 32'h0E, 32'd129, 0, 3'd0, 13,  1, 0);

    resetDut();
    checkVal("reset_rom_mapped", -1, {31'd0, rom_mapped}, 32'd0);
    checkVal("reset_busy", -1, {31'd0, busy}, 32'd0);
    checkVal("reset_parse_error", -1, {31'd0, parse_error}, 32'd0);
    checkVal("reset_error_code", -1, {29'd0, error_code}, 32'd0);
    checkVal("reset_first_instruction", -1, first_instruction, 32'd0);
    checkVal("reset_func_count", -1, func_count, 32'd0);
    checkVal("reset_read_en", -1, {31'd0, bus.memory_read_en}, 32'd0);
    checkVal("write_en_granted", -1, {31'd0, bus.memory_write_en}, 32'd0);

    for (int i = 0; i < NVEC; i++) applyStimulus(vecs[i], i);

    // Reset asserted while the section size byte is being requested.
    resetDut();
    loadRom(vecs[0]);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 500; c++) begin
      if (bus.memory_read_en === 1'b1 && bus.addr === 32'd9) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkVal("reached_sec_size", 100, {31'd0, seen}, 32'd1);
    checkVal("busy_mid_parse", 100, {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkVal("async_busy", 100, {31'd0, busy}, 32'd0);
    checkVal("async_read_en", 100, {31'd0, bus.memory_read_en}, 32'd0);
    checkVal("async_rom_mapped", 100, {31'd0, rom_mapped}, 32'd0);
    checkVal("async_func_count", 100, func_count, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    loadRom(vecs[0]);
    startAndWait(100);
    repeat (3) @(negedge clk);
    checkOutput(vecs[0], 100);

    // Bus grant withdrawn mid-parse stalls the parser without losing bytes.
    resetDut();
    loadRom(vecs[3]);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (25) @(negedge clk);
    bus.mem_access = 1'b0;
    repeat (40) @(negedge clk);
    checkVal("stall_busy", 101, {31'd0, busy}, 32'd1);
    checkVal("stall_rom_mapped", 101, {31'd0, rom_mapped}, 32'd0);
    bus.mem_access = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!busy) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkVal("stall_finished", 101, {31'd0, seen}, 32'd1);
    repeat (3) @(negedge clk);
    checkOutput(vecs[3], 101);

    // A start pulse in DONE must not restart the parse.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    checkVal("done_ignores_start_busy", 102, {31'd0, busy}, 32'd0);
    checkVal("done_ignores_start_mapped", 102, {31'd0, rom_mapped}, 32'd1);
    checkVal("done_ignores_start_read_en", 102, {31'd0, bus.memory_read_en}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
